// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: producer side of the 2-bit character-code interface that
// feeds the four HEX digit decoders. It holds a small writable message buffer
// and presents a 4-character window (c3 = leftmost digit ... c0 = rightmost).
// The window scrolls on a prescaled timer tick or on a manual step, in either
// direction.
//
// Ports:
//   CLOCK_50  system clock; all logic runs on its rising edge
//   rst       synchronous reset, active-high
//   en        enables the automatic scroll prescaler
//   dir       scroll direction (0 = pointer increments, 1 = pointer decrements)
//   step      manual advance; level input, rising edge detected internally
//   wr_en     message buffer write strobe
//   wr_addr   write address; addresses >= MSG_LEN are ignored
//   wr_data   character code to write
//   c3..c0    registered window codes msg[ptr .. ptr+3] (indices mod MSG_LEN)
//   pos       current window pointer
//   adv       one-cycle pulse, high in the cycle the pointer takes its new value
module seg_msg_scroller #(
  parameter int TICK_DIV = 50000000,
  parameter int MSG_LEN  = 8
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       step,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [1:0] wr_data,
  output logic [1:0] c3,
  output logic [1:0] c2,
  output logic [1:0] c1,
  output logic [1:0] c0,
  output logic [3:0] pos,
  output logic       adv
);

  localparam int             CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int             IDX_W   = $clog2(MSG_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [3:0]     PTR_MAX = 4'(MSG_LEN - 1);
  localparam logic [4:0]     LEN5    = 5'(MSG_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ptr_q, ptr_d;
  logic             step_q;
  logic             adv_q;
  logic [1:0]       msg_q [MSG_LEN];
  logic [1:0]       c3_q, c2_q, c1_q, c0_q;

  logic tick, stp, go, wr_ok;

  // Window index ptr+k modulo MSG_LEN. ptr < MSG_LEN and k <= 3 < MSG_LEN,
  // so a single compare-and-subtract is enough for any buffer length.
  function automatic logic [IDX_W-1:0] win_idx(input logic [3:0] p, input logic [2:0] k);
    logic [4:0] s;
    s = {1'b0, p} + {2'b00, k};
    if (s >= LEN5) s = s - LEN5;
    return IDX_W'(s);
  endfunction

  always_comb begin
    tick  = en && (cnt_q == CNT_MAX);
    stp   = step && !step_q;
    go    = tick || stp;
    wr_ok = wr_en && ({1'b0, wr_addr} < LEN5);

    // With en low the count freezes rather than clearing.
    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;

    // dir only matters in a cycle where an advance actually happens.
    ptr_d = ptr_q;
    if (go) begin
      if (dir) ptr_d = (ptr_q == 4'd0) ? PTR_MAX : ptr_q - 4'd1;
      else     ptr_d = (ptr_q == PTR_MAX) ? 4'd0 : ptr_q + 4'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      cnt_q  <= '0;
      ptr_q  <= '0;
      step_q <= 1'b0;
      adv_q  <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= 2'(i);
      c3_q <= 2'd0;
      c2_q <= 2'd1;
      c1_q <= 2'd2;
      c0_q <= 2'd3;
    end else begin
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      step_q <= step;
      adv_q  <= go;
      // Window is rebuilt from the pre-edge buffer and pointer, so a new
      // pointer or a fresh write shows up one edge after it lands.
      c3_q <= msg_q[win_idx(ptr_q, 3'd0)];
      c2_q <= msg_q[win_idx(ptr_q, 3'd1)];
      c1_q <= msg_q[win_idx(ptr_q, 3'd2)];
      c0_q <= msg_q[win_idx(ptr_q, 3'd3)];
      if (wr_ok) msg_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign c3  = c3_q;
  assign c2  = c2_q;
  assign c1  = c1_q;
  assign c0  = c0_q;
  assign pos = ptr_q;
  assign adv = adv_q;

endmodule
